// File: rtl/sub_seq_pkg.sv
// Shared types, display glyphs and the hex-to-segment decoder for the
// switch/button/seven-segment calculator blocks (adder and subtractor).
package sub_seq_pkg;

    typedef enum logic [1:0] {
        StEnterA,
        StEnterB,
        StShow
    } state_e;

    // Full digit word {DIG_n, DP, g..a}: digit dark, all segments off.
    localparam logic [8:0] SEG_OFF = 9'h100;

    // Segment glyphs, bit order g..a, active-high.
    localparam logic [6:0] SEG_MINUS    = 7'h40;
    localparam logic [6:0] SEG_A_PROMPT = 7'h77;
    localparam logic [6:0] SEG_B_PROMPT = 7'h7C;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        unique case (v)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            default: seg = SEG_HEX_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sub_seq_if.sv
// Board-facing signal bundle: switches/button in, display and result out.
interface sub_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] num;
    logic             button;
    logic [8:0]       seg_led_1;
    logic [8:0]       seg_led_2;
    logic [WIDTH:0]   diff;
    logic             diff_valid;

    modport master (
        output num,
        output button,
        input  seg_led_1,
        input  seg_led_2,
        input  diff,
        input  diff_valid
    );

    modport slave (
        input  num,
        input  button,
        output seg_led_1,
        output seg_led_2,
        output diff,
        output diff_valid
    );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debouncer and a
// one-cycle press pulse on a debounced 1->0 (active-low press) transition.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic press_o
);
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;
    logic [1:0]      flush_q, flush_d;
    logic            armed_q, armed_d;

    // Synchronizer, debounce state and press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            flush_q  <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= button_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            flush_q  <= flush_d;
            armed_q  <= armed_d;
        end
    end

    // Count consecutive mismatches; any gap restarts the count.
    // Presses are suppressed until the button has been seen released after
    // reset (once the synchronizer has flushed its reset value), so a button
    // held through reset never yields a press.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = sync2_q;
                press_d  = armed_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        flush_d = flush_q[1] ? flush_q : flush_q + 2'd1;
        armed_d = armed_q | (flush_q[1] & stable_q & sync2_q);
    end

    assign press_o = press_q;

endmodule

// File: rtl/sub_seq.sv
// Sequential subtractor: enter A, enter B, show signed A-B as sign + hex digit.
module sub_seq
    import sub_seq_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
    input  logic     clk,
    input  logic     rst_n,
    sub_seq_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] num_s1_q, num_sync_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic [8:0]       seg1_q, seg1_d, seg2_q, seg2_d;
    logic [WIDTH-1:0] mag;
    logic             press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .rst_n    (rst_n),
        .button_i (bus.button),
        .press_o  (press)
    );

    // Switch synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_s1_q   <= '0;
            num_sync_q <= '0;
        end else begin
            num_s1_q   <= bus.num;
            num_sync_q <= num_s1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEnterA;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: advance only on a press pulse.
    always_comb begin
        state_d = state_q;
        if (press) begin
            unique case (state_q)
                StEnterA: state_d = StEnterB;
                StEnterB: state_d = StShow;
                StShow:   state_d = StEnterB;
                default:  state_d = StEnterA;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        bus.diff_valid = (state_q == StShow);
    end

    // Operand, result and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            diff_q <= '0;
            seg1_q <= SEG_OFF;
            seg2_q <= SEG_OFF;
        end else begin
            a_q    <= a_d;
            diff_q <= diff_d;
            seg1_q <= seg1_d;
            seg2_q <= seg2_d;
        end
    end

    // Operand capture and subtraction. B is consumed in its capture cycle
    // straight from the switches, so it needs no register of its own.
    always_comb begin
        a_d    = a_q;
        diff_d = diff_q;
        if (press) begin
            unique case (state_q)
                StEnterA, StShow: a_d = num_sync_q;
                StEnterB:         diff_d = {1'b0, a_q} - {1'b0, num_sync_q};
                default:          a_d = a_q;
            endcase
        end
    end

    // Display next value from current state, switches and result.
    always_comb begin
        mag    = diff_q[WIDTH] ? WIDTH'(0 - diff_q) : diff_q[WIDTH-1:0];
        seg1_d = SEG_OFF;
        seg2_d = SEG_OFF;
        unique case (state_q)
            StEnterA: begin
                seg1_d = {2'b00, SEG_A_PROMPT};
                seg2_d = {2'b00, hex_to_seg(num_sync_q)};
            end
            StEnterB: begin
                seg1_d = {2'b00, SEG_B_PROMPT};
                seg2_d = {2'b00, hex_to_seg(num_sync_q)};
            end
            StShow: begin
                seg1_d = diff_q[WIDTH] ? {2'b00, SEG_MINUS} : SEG_OFF;
                seg2_d = {2'b00, hex_to_seg(mag)};
            end
            default: ;
        endcase
    end

    assign bus.seg_led_1 = seg1_q;
    assign bus.seg_led_2 = seg2_q;
    assign bus.diff      = diff_q;

endmodule

// File: tb/tb_sub_seq.sv
// Directed bench for sub_seq with a short debounce window.
module tb_sub_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sub_seq_if #(.WIDTH(4)) bus_if ();

    sub_seq #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] v);
        bus_if.num = v;
        tick(3);
        bus_if.button = 1'b0;
        tick(12);
        bus_if.button = 1'b1;
        tick(12);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus_if.num    = 4'd3;
        bus_if.button = 1'b1;
        tick(2);
        chk("rst_seg1", bus_if.seg_led_1, 9'h100);
        chk("rst_seg2", bus_if.seg_led_2, 9'h100);
        chk("rst_diff", {4'd0, bus_if.diff}, 9'h000);
        chk("rst_valid", {8'd0, bus_if.diff_valid}, 9'h000);

        rst_n = 1'b1;
        tick(6);
        chk("idle_seg1", bus_if.seg_led_1, 9'h077);
        chk("idle_seg2", bus_if.seg_led_2, 9'h04F);
        chk("idle_valid", {8'd0, bus_if.diff_valid}, 9'h000);

        // 9 - 4 = +5
        press(4'd9);
        chk("entb_seg1", bus_if.seg_led_1, 9'h07C);
        chk("entb_seg2", bus_if.seg_led_2, 9'h06F);
        press(4'd4);
        chk("p5_diff", {4'd0, bus_if.diff}, 9'h005);
        chk("p5_valid", {8'd0, bus_if.diff_valid}, 9'h001);
        chk("p5_seg1", bus_if.seg_led_1, 9'h100);
        chk("p5_seg2", bus_if.seg_led_2, 9'h06D);

        // SHOW -> ENTER_B with A=2, then 2 - 7 = -5
        press(4'd2);
        chk("reent_seg1", bus_if.seg_led_1, 9'h07C);
        chk("reent_valid", {8'd0, bus_if.diff_valid}, 9'h000);
        chk("reent_diff_hold", {4'd0, bus_if.diff}, 9'h005);
        press(4'd7);
        chk("m5_diff", {4'd0, bus_if.diff}, 9'h01B);
        chk("m5_seg1", bus_if.seg_led_1, 9'h040);
        chk("m5_seg2", bus_if.seg_led_2, 9'h06D);

        // 0 - 15 = -15
        press(4'd0);
        press(4'd15);
        chk("m15_diff", {4'd0, bus_if.diff}, 9'h011);
        chk("m15_seg1", bus_if.seg_led_1, 9'h040);
        chk("m15_seg2", bus_if.seg_led_2, 9'h071);

        // 6 - 6 = 0
        press(4'd6);
        chk("a6_seg1", bus_if.seg_led_1, 9'h07C);
        chk("a6_seg2", bus_if.seg_led_2, 9'h07D);
        chk("a6_valid", {8'd0, bus_if.diff_valid}, 9'h000);
        press(4'd6);
        chk("z_diff", {4'd0, bus_if.diff}, 9'h000);
        chk("z_seg1", bus_if.seg_led_1, 9'h100);
        chk("z_seg2", bus_if.seg_led_2, 9'h03F);

        // 15 - 0 = +15
        press(4'd15);
        press(4'd0);
        chk("p15_diff", {4'd0, bus_if.diff}, 9'h00F);
        chk("p15_seg1", bus_if.seg_led_1, 9'h100);
        chk("p15_seg2", bus_if.seg_led_2, 9'h071);

        // Bounce: exactly one press, ENTER_A -> ENTER_B only
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        bus_if.button = 1'b0;
        tick(2);
        bus_if.button = 1'b1;
        tick(1);
        bus_if.button = 1'b0;
        tick(53);
        bus_if.button = 1'b1;
        tick(12);
        chk("bounce_seg1", bus_if.seg_led_1, 9'h07C);
        chk("bounce_valid", {8'd0, bus_if.diff_valid}, 9'h000);

        // Reset mid-entry with button held
        bus_if.button = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("arst_seg1", bus_if.seg_led_1, 9'h100);
        chk("arst_seg2", bus_if.seg_led_2, 9'h100);
        chk("arst_diff", {4'd0, bus_if.diff}, 9'h000);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("held_seg1", bus_if.seg_led_1, 9'h077);
        bus_if.button = 1'b1;
        tick(12);
        chk("rel_seg1", bus_if.seg_led_1, 9'h077);
        press(4'd5);
        chk("after_seg1", bus_if.seg_led_1, 9'h07C);
        chk("after_seg2", bus_if.seg_led_2, 9'h06D);

        // num changes inside the debounce window: 5 - 8 = -3
        bus_if.num    = 4'd1;
        bus_if.button = 1'b0;
        tick(2);
        bus_if.num = 4'd8;
        tick(12);
        bus_if.button = 1'b1;
        tick(12);
        chk("late_diff", {4'd0, bus_if.diff}, 9'h01D);
        chk("late_seg1", bus_if.seg_led_1, 9'h040);
        chk("late_seg2", bus_if.seg_led_2, 9'h04F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sub_seq.md
Name: sub_seq

Overview:
- Sequential 4-bit subtractor for the switch/button/7-segment board flow. It is the inverse operation of the existing button-driven adder.
- Operand A (minuend) and operand B (subtrahend) are entered on the 4 switches. Each is latched by a debounced press of the button.
- The signed difference A−B is shown on the two 9-bit seven-segment outputs as a sign digit and a hex magnitude digit.
- Sits at top level next to the adder and drives the same two display digits.

Parameters:
- WIDTH, 4, operand width; the display encoding is defined for 4 only.
- DEBOUNCE_CYCLES, 240000, number of consecutive stable clk cycles required to accept a button level change (20 ms at 12 MHz).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- num  input  WIDTH  operand switches, asynchronous, quasi-static.
- button  input  1  raw push button, active-low (0 = pressed), bouncing.
- seg_led_1  output  9  left digit {DIG_n, DP, g,f,e,d,c,b,a}; DIG_n=0 lights the digit; segments active-high.
- seg_led_2  output  9  right digit, same format as seg_led_1.
- diff  output  WIDTH+1  two's-complement A−B, registered.
- diff_valid  output  1  high while in SHOW state.

Behaviour:
- Reset (async, rst_n=0):
  - state=ENTER_A, A=B=0, diff=0, diff_valid=0.
  - seg_led_1=seg_led_2=9'h100 (digit off, segments off).
  - Debounce and synchronizer flops are cleared to the released level (1).
- Input conditioning:
  - button and num each pass through a 2-FF synchronizer.
  - The debouncer holds a stable level. It updates that level only after the synchronized button differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
  - press = 1-cycle pulse on a debounced 1→0 transition. Release produces no event. A held button produces exactly one press.
- FSM, advancing only on the press pulse:
  - ENTER_A --press--> A<=num_sync, goto ENTER_B.
  - ENTER_B --press--> B<=num_sync, diff<=A−B (computed on the captured values: A and new num_sync), goto SHOW.
  - SHOW --press--> A<=num_sync, goto ENTER_B. diff holds its old value; diff_valid drops.
- Arithmetic:
  - diff = {1'b0,A} − {1'b0,B}, 5-bit two's complement, range −15..+15.
  - No saturation and no carry-out port.
  - Magnitude = |diff| (0..15).
- Display is registered, updated every cycle from the current state and values. seg_led changes one cycle after the state or num_sync changes.
  - ENTER_A: seg_led_1 shows 'A' (0x77); seg_led_2 shows live hex num_sync.
  - ENTER_B: seg_led_1 shows 'b' (0x7C); seg_led_2 shows live hex num_sync.
  - SHOW: seg_led_1 shows '-' (0x40) if diff<0, else blank (DIG_n=1); seg_led_2 shows hex magnitude.
  - DP is always 0.
- Hex codes (g..a): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Boundaries:
  - A=B gives diff=0, shown as blank + '0'.
  - 0−15 gives diff=−15 (5'b10001), shown as '-' + 'F'.
  - 15−0 gives +15, shown as blank + 'F'.
  - Bounce shorter than DEBOUNCE_CYCLES produces no event.
  - num changing during the debounce window: the value captured is num_sync in the press-pulse cycle.
  - Reset asserted mid-debounce or mid-entry aborts everything to the reset state. No press is generated on reset release, even if the button is held.

Decomposition:
- Shared package sub_seq_pkg:
  - state enum {ENTER_A, ENTER_B, SHOW};
  - SEG_OFF = 9'h100;
  - 7-bit constants for the hex glyphs, SEG_MINUS, SEG_A_PROMPT, SEG_B_PROMPT;
  - a hex→segment function. The adder's display path should reuse this function.
- Sub-module btn_debounce (synchronizer + counter + press pulse), parameterized by DEBOUNCE_CYCLES. It is reusable for the adder's button.

Test Plan (DEBOUNCE_CYCLES=4 in bench):
- Reset, then idle → seg_led_1=9'h077, seg_led_2 tracks num (num=3 → 9'h04F); diff_valid=0.
- num=9 press, num=4 press → diff=5'b00101, diff_valid=1, seg_led_1=9'h100, seg_led_2=9'h06D.
- num=2 press, num=7 press → diff=5'b11011 (−5), seg_led_1=9'h040, seg_led_2=9'h06D. Then num=0 press, num=15 press → diff=−15, seg_led_2=9'h071.
- Button bounces (low 2 cycles, high 1, low 3, then held low 50 cycles) → exactly one press; state moves ENTER_A→ENTER_B only.
- In SHOW, press with num=6 → state ENTER_B, A=6, seg_led_1=9'h07C, diff_valid=0. Then num=6 press → diff=0, seg_led_1=9'h100, seg_led_2=9'h03F.
- Assert rst_n=0 while in ENTER_B with button held → outputs 9'h100/diff=0 immediately. After release, no press until the button is released and pressed again.
